rgb_pwm_fader: RTL and testbench

Parametrised successor to the single-LED RGB PWM driver. It takes packed RGB565-style colour words through a valid/ready handshake and drives NUM_LEDS RGB LEDs with PWM. Each LED fades linearly from its current colour to a newly loaded target, one LSB per step. It sits between the board switch/command logic and the LED pins.

---
 rtl/rgb_pwm_fader_pkg.sv | 23 ++
 rtl/rgb_pwm_fader_channel.sv | 70 +++++++
 rtl/rgb_pwm_fader.sv | 131 +++++++++++++
 tb/tb_rgb_pwm_fader.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/rgb_pwm_fader_pkg.sv
// Shared types and constant helpers for the RGB PWM fader.
// FSM state encoding and width-derivation functions used by the top
// and the per-component channel.
package rgb_pwm_fader_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FADE = 1'b1
  } state_e;

  // Widest of the three colour fields; sets the PWM counter width.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rgb_pwm_fader_channel.sv
// One colour component of one LED: current/target registers, a +/-1
// step toward the target, expansion to the PWM width, optional gamma,
// the period-synchronous duty register and the output comparator.
// Optional feature macro: RGB_PWM_GAMMA_EN (square-law duty mapping).
module rgb_pwm_fader_channel
  import rgb_pwm_fader_pkg::*;
#(
  parameter int FB = 5,
  parameter int W  = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [FB-1:0] tgt_i,
  input  logic          step_i,
  input  logic          pb_i,
  input  logic [W-1:0]  pwm_cnt_i,
  output logic [FB-1:0] cur_o,
  output logic          settle_o,
  output logic          pwm_o
);

  logic [FB-1:0] cur_q, cur_d, cur_step, tgt_q;
  logic [W-1:0]  exp_val, duty_val, duty_q;
  logic          pwm_q;

  // One LSB toward the target; settle_o tells the top this step lands on it.
  always_comb begin
    cur_step = cur_q;
    if (cur_q < tgt_q)      cur_step = cur_q + 1'b1;
    else if (cur_q > tgt_q) cur_step = cur_q - 1'b1;
    cur_d    = step_i ? cur_step : cur_q;
    settle_o = (cur_step == tgt_q);
  end

  // Left-justify and refill the low bits by repeating the field from its MSB.
  always_comb begin
    exp_val = '0;
    for (int k = 0; k < W; k++) begin
      exp_val[W-1-k] = cur_q[FB-1-(k % FB)];
    end
  end

`ifdef RGB_PWM_GAMMA_EN
  logic [2*W-1:0] sq;
  assign sq       = {{W{1'b0}}, exp_val} * {{W{1'b0}}, exp_val};
  assign duty_val = W'(sq >> W);
`else
  assign duty_val = exp_val;
`endif

  // Component state, duty reload on period boundary, registered PWM compare.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_q  <= '0;
      tgt_q  <= '0;
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      if (load_i) tgt_q <= tgt_i;
      cur_q <= cur_d;
      if (pb_i) duty_q <= duty_val;
      pwm_q <= (pwm_cnt_i < duty_q);
    end
  end

  assign cur_o = cur_q;
  assign pwm_o = pwm_q;

endmodule

// File: rtl/rgb_pwm_fader.sv
// Multi-LED RGB PWM driver with linear fading between colours.
// Holds the prescaler, PWM counter, fade-period counter, IDLE/FADE FSM
// and the colour handshake; per-component work lives in the channels.
// Optional feature macro: RGB_PWM_GAMMA_EN (applied inside each channel).
module rgb_pwm_fader
  import rgb_pwm_fader_pkg::*;
#(
  parameter int NUM_LEDS     = 2,
  parameter int R_BITS       = 5,
  parameter int G_BITS       = 6,
  parameter int B_BITS       = 5,
  parameter int PRESCALE     = 16,
  parameter int FADE_PERIODS = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [R_BITS+G_BITS+B_BITS-1:0]   color_in,
  input  logic [cnt_width(NUM_LEDS)-1:0]    led_sel,
  input  logic                              color_valid,
  output logic                              color_ready,
  output logic                              busy,
  output logic [NUM_LEDS-1:0]               rLED,
  output logic [NUM_LEDS-1:0]               gLED,
  output logic [NUM_LEDS-1:0]               bLED
);

  localparam int PIX_W = R_BITS + G_BITS + B_BITS;
  localparam int W     = max3(R_BITS, G_BITS, B_BITS);
  localparam int SEL_W = cnt_width(NUM_LEDS);
  localparam int PS_W  = cnt_width(PRESCALE);
  localparam int FC_W  = cnt_width(FADE_PERIODS);

  logic [PS_W-1:0] presc_q, presc_d;
  logic [W-1:0]    pwm_cnt_q, pwm_cnt_d;
  logic [FC_W-1:0] fade_cnt_q, fade_cnt_d;
  state_e          state_q, state_d;
  logic            run_q;
  logic            tick, pb, step, accept, in_range, same, all_settle;

  logic [R_BITS-1:0] col_r;
  logic [G_BITS-1:0] col_g;
  logic [B_BITS-1:0] col_b;
  logic [R_BITS-1:0] r_cur [NUM_LEDS];
  logic [G_BITS-1:0] g_cur [NUM_LEDS];
  logic [B_BITS-1:0] b_cur [NUM_LEDS];
  logic [NUM_LEDS-1:0] sel_hit, same_hit, r_settle, g_settle, b_settle;

  assign col_r = color_in[PIX_W-1 -: R_BITS];
  assign col_g = color_in[B_BITS +: G_BITS];
  assign col_b = color_in[B_BITS-1:0];

  // Timebase: prescaler tick, PWM counter, period boundary, fade step strobe.
  always_comb begin
    tick       = (presc_q == PS_W'(PRESCALE - 1));
    pb         = tick && (pwm_cnt_q == '1);
    step       = (state_q == ST_FADE) && pb && (fade_cnt_q == FC_W'(FADE_PERIODS - 1));
    presc_d    = tick ? '0 : presc_q + 1'b1;
    pwm_cnt_d  = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    fade_cnt_d = fade_cnt_q;
    if (accept)                           fade_cnt_d = '0;
    else if ((state_q == ST_FADE) && pb)  fade_cnt_d = step ? '0 : fade_cnt_q + 1'b1;
  end

  // Counter registers; run_q lets color_ready rise one edge after reset ends.
  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_q    <= '0;
      pwm_cnt_q  <= '0;
      fade_cnt_q <= '0;
      run_q      <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      pwm_cnt_q  <= pwm_cnt_d;
      fade_cnt_q <= fade_cnt_d;
      run_q      <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LEDS; gi++) begin : g_led
      assign sel_hit[gi]  = (led_sel == SEL_W'(gi));
      assign same_hit[gi] = sel_hit[gi] && (r_cur[gi] == col_r) &&
                            (g_cur[gi] == col_g) && (b_cur[gi] == col_b);

      rgb_pwm_fader_channel #(.FB(R_BITS), .W(W)) u_r (
        .clk(clk), .rst(rst), .load_i(accept && sel_hit[gi]), .tgt_i(col_r),
        .step_i(step), .pb_i(pb), .pwm_cnt_i(pwm_cnt_q),
        .cur_o(r_cur[gi]), .settle_o(r_settle[gi]), .pwm_o(rLED[gi]));

      rgb_pwm_fader_channel #(.FB(G_BITS), .W(W)) u_g (
        .clk(clk), .rst(rst), .load_i(accept && sel_hit[gi]), .tgt_i(col_g),
        .step_i(step), .pb_i(pb), .pwm_cnt_i(pwm_cnt_q),
        .cur_o(g_cur[gi]), .settle_o(g_settle[gi]), .pwm_o(gLED[gi]));

      rgb_pwm_fader_channel #(.FB(B_BITS), .W(W)) u_b (
        .clk(clk), .rst(rst), .load_i(accept && sel_hit[gi]), .tgt_i(col_b),
        .step_i(step), .pb_i(pb), .pwm_cnt_i(pwm_cnt_q),
        .cur_o(b_cur[gi]), .settle_o(b_settle[gi]), .pwm_o(bLED[gi]));
    end
  endgenerate

  // Out-of-range selects hit no LED, so the word is taken and dropped.
  assign in_range   = |sel_hit;
  assign same       = |same_hit;
  assign all_settle = &{r_settle, g_settle, b_settle};
  assign accept     = color_valid && color_ready;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // FSM next state: fade only when a real change is requested; stop once all settle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && in_range && !same) state_d = ST_FADE;
      ST_FADE: if (step && all_settle)          state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    color_ready = run_q && (state_q == ST_IDLE);
    busy        = (state_q == ST_FADE);
  end

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Directed bench for rgb_pwm_fader: PRESCALE=1, FADE_PERIODS=1, NUM_LEDS=3
// (so led_sel=3 is an out-of-range index). Expected duties are hand-expanded
// component values, optionally squared when RGB_PWM_GAMMA_EN is defined.
module tb_rgb_pwm_fader;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] color_in;
  logic [1:0]  led_sel;
  logic        color_valid;
  logic        color_ready, busy;
  logic [2:0]  rLED, gLED, bLED;

  int tests = 0;
  int fails = 0;
  int hr[3], hg[3], hb[3];
  int n, k, tot;

  rgb_pwm_fader #(
    .NUM_LEDS(3), .R_BITS(5), .G_BITS(6), .B_BITS(5),
    .PRESCALE(1), .FADE_PERIODS(1)
  ) dut (
    .clk(clk), .rst(rst), .color_in(color_in), .led_sel(led_sel),
    .color_valid(color_valid), .color_ready(color_ready), .busy(busy),
    .rLED(rLED), .gLED(gLED), .bLED(bLED)
  );

  always #5 clk = ~clk;

  function automatic int dmap(input int e);
`ifdef RGB_PWM_GAMMA_EN
    return (e * e) >> 6;
`else
    return e;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Offer one word for one edge; called and returns at a falling edge.
  task automatic send(input logic [1:0] sel, input logic [15:0] col);
    led_sel     = sel;
    color_in    = col;
    color_valid = 1'b1;
    $display("[TB] send led=%0d color=%h ready=%0b", sel, col, color_ready);
    @(negedge clk);
    color_valid = 1'b0;
  endtask

  task automatic wait_ready(input int limit, input string tag);
    int c;
    c = 0;
    while (color_ready !== 1'b1 && c < limit) begin
      @(negedge clk);
      c++;
    end
    check(tag, 32'(color_ready), 32'd1);
  endtask

  // High-cycle count of every output over one full 64-tick PWM period.
  task automatic count_window();
    for (int i = 0; i < 3; i++) begin
      hr[i] = 0; hg[i] = 0; hb[i] = 0;
    end
    repeat (64) begin
      for (int i = 0; i < 3; i++) begin
        hr[i] += int'(rLED[i]);
        hg[i] += int'(gLED[i]);
        hb[i] += int'(bLED[i]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b0; color_valid = 1'b0; color_in = '0; led_sel = '0;

    // Reset held for 10 edges.
    repeat (10) @(negedge clk);
    check("rst_r", 32'(rLED), 32'd0);
    check("rst_g", 32'(gLED), 32'd0);
    check("rst_b", 32'(bLED), 32'd0);
    check("rst_ready", 32'(color_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(color_ready), 32'd1);

    // Small colour on LED0: expanded R=2, G=1, B=2.
    send(2'd0, 16'h0821);
    check("load1_busy", 32'(busy), 32'd1);
    check("load1_ready_low", 32'(color_ready), 32'd0);
    wait_ready(200, "load1_done");
    repeat (140) @(negedge clk);
    count_window();
    check("l1_r0", 32'(hr[0]), 32'(dmap(2)));
    check("l1_g0", 32'(hg[0]), 32'(dmap(1)));
    check("l1_b0", 32'(hb[0]), 32'(dmap(2)));
    check("l1_led1_off", 32'(hr[1] + hg[1] + hb[1]), 32'd0);
    check("l1_led2_off", 32'(hr[2] + hg[2] + hb[2]), 32'd0);

    // Back to black, then full red: 31 steps, one per 64-cycle period.
    send(2'd0, 16'h0000);
    wait_ready(200, "black_done");
    send(2'd0, 16'hF800);
    n = 0;
    while (busy === 1'b1 && n < 2100) begin
      n++;
      if (n == 500) begin
        led_sel = 2'd0; color_in = 16'h001F; color_valid = 1'b1;
      end
      if (n == 560) check("offer_while_busy_ready", 32'(color_ready), 32'd0);
      if (n == 600) color_valid = 1'b0;
      @(negedge clk);
    end
    check("red_fade_len_in_range", 32'(n >= 1921 && n <= 1984), 32'd1);
    check("red_fade_ready", 32'(color_ready), 32'd1);
    repeat (140) @(negedge clk);
    count_window();
    check("red_r0", 32'(hr[0]), 32'(dmap(63)));
    check("red_g0_target_kept", 32'(hg[0]), 32'd0);
    check("red_b0_target_kept", 32'(hb[0]), 32'd0);

    // The blue word is accepted once ready is back.
    send(2'd0, 16'h001F);
    check("blue_accepted_busy", 32'(busy), 32'd1);
    wait_ready(31 * 64 + 100, "blue_done");
    repeat (140) @(negedge clk);
    count_window();
    check("blue_r0", 32'(hr[0]), 32'd0);
    check("blue_b0", 32'(hb[0]), 32'(dmap(63)));

    // Green on LED1 (field already 6 bits wide).
    send(2'd1, 16'h07E0);
    check("green_busy", 32'(busy), 32'd1);
    wait_ready(63 * 64 + 100, "green_done");
    repeat (140) @(negedge clk);
    count_window();
    check("green_g1", 32'(hg[1]), 32'(dmap(63)));
    check("green_rb1", 32'(hr[1] + hb[1]), 32'd0);
    check("green_b0_kept", 32'(hb[0]), 32'(dmap(63)));

    // Out-of-range select: taken and dropped.
    send(2'd3, 16'hFFFF);
    check("discard_ready", 32'(color_ready), 32'd1);
    check("discard_busy", 32'(busy), 32'd0);
    repeat (140) @(negedge clk);
    count_window();
    check("discard_led2_off", 32'(hr[2] + hg[2] + hb[2]), 32'd0);
    check("discard_g1_kept", 32'(hg[1]), 32'(dmap(63)));

    // Identical colour: no fade.
    send(2'd1, 16'h07E0);
    check("same_ready", 32'(color_ready), 32'd1);
    check("same_busy", 32'(busy), 32'd0);

    // Reset in the middle of a fade, on an edge where an output is high.
    send(2'd2, 16'hFFFF);
    repeat (200) @(negedge clk);
    check("midfade_busy", 32'(busy), 32'd1);
    k = 0;
    while (bLED[0] !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("b0_high_before_rst", 32'(bLED[0]), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_r", 32'(rLED), 32'd0);
    check("midrst_g", 32'(gLED), 32'd0);
    check("midrst_b", 32'(bLED), 32'd0);
    check("midrst_ready", 32'(color_ready), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_midrst", 32'(color_ready), 32'd1);
    repeat (140) @(negedge clk);
    count_window();
    tot = 0;
    for (int i = 0; i < 3; i++) tot += hr[i] + hg[i] + hb[i];
    check("all_dark_after_midrst", 32'(tot), 32'd0);
    check("idle_after_midrst", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
